mux_rr_scheduler: RTL and testbench
===================================

# mux_rr_scheduler

Round-robin scheduler that shares one 8-to-1 bit multiplexer among eight requesters. It decides which input drives the shared output, produces the 3-bit mux select, and enforces a bounded hold time per grant. It also contains the registered 8-to-1 datapath it controls. It sits between the requesting agents and the downstream single-bit consumer.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one requester keeps the grant while another requester is waiting. Legal range is 2..256.
- clk  input  1  rising-edge clock; the only clock domain.
- reset  input  1  synchronous, active-high reset.
- req  input  8  level request per source; bit k requests input k.
- in  input  8  data bits; bit k belongs to source k.
- grant  output  8  registered one-hot grant; all zeros when idle.
- select  output  3  registered binary index of the current grantee.
- active  output  1  registered; high while any grant is held.
- out  output  1  registered muxed data, equal to in[select] from the previous cycle.
- out_valid  output  1  registered; equal to active from the previous cycle.

## Operation
- Two states:
  - IDLE: no grant is held.
  - GRANT: grant[owner] is high and select = owner.
- Priority pointer ptr[2:0]:
  - The search order is ptr, ptr+1, …, ptr+7, modulo 8, so the pointer wraps from 7 to 0.
  - Each time a new grant is issued to source k, ptr becomes k+1 mod 8.
- IDLE transitions:
  - If req is nonzero, grant the first requester in pointer order and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, when req[owner] drops:
  - If any other req is high, grant the next requester in pointer order directly, with no idle cycle.
  - Otherwise go to IDLE.
- GRANT, when req[owner] stays high:
  - Hold counter hold_cnt is $clog2(MAX_HOLD) bits wide, is cleared on every new grant, and increments each cycle in GRANT.
  - When hold_cnt == MAX_HOLD-1 and another req is high, rotate to the next requester in pointer order. The owner is excluded from the search, even though ptr may point at it.
  - When hold_cnt == MAX_HOLD-1 and no other request is pending, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1. Preemption then occurs on the first cycle a contender appears.
- Simultaneous events: if the owner drops its request in the same cycle the hold limit is reached, this is treated as a release. The result is the same grant choice; no double advance of ptr.
- A request that appears and disappears while another source owns the grant is never served. There is no request latching.
- Datapath:
  - out <= active ? in[select] : 0
  - out_valid <= active
- Reset values, for every register:
  - grant = 0, select = 0, active = 0, out = 0, out_valid = 0
  - ptr = 0, hold_cnt = 0, state = IDLE
- Reset mid-operation drops the grant on the next edge, with no completion of the current hold.

## Timing
- Arbitration decisions are made combinationally from req and the registered state, and take effect on the next clk edge.
- Latency from req to grant: 1 cycle.
- Grant to first valid out: 1 further cycle.
- Handover on release or preemption: grant changes on the edge after the triggering req sample, with zero idle cycles between owners.
- Fairness bound: with all 8 sources requesting continuously, each source is served at least once every 8*MAX_HOLD cycles.
- reset has priority over all other events in the same cycle.

## Structure
- Shared include mux_defs.vh holds:
  - N_SRC = 8 and SEL_W = 3
  - the state encodings ST_IDLE and ST_GRANT
- Sub-module rr_pick: a combinational rotating-priority picker.
  - Inputs: req[7:0], ptr[2:0], excl_en, excl_idx[2:0].
  - Outputs: found and idx[2:0].
  - Instantiated once, and reused for both the IDLE pick and the GRANT handover pick.

## Test plan
- Reset then single request: req = 8'h10 → grant = 8'h10 and select = 4 one cycle later; out follows in[4] one cycle after that; ptr becomes 5.
- Round-robin wrap: ptr = 6 and req = 8'h41 (sources 0 and 6) → source 6 is granted. When source 6 releases, source 0 is granted with no idle cycle; active stays high throughout.
- Hold limit with MAX_HOLD = 4: req = 8'h03 held continuously → source 0 is granted for 4 cycles, then source 1 for 4 cycles, alternating indefinitely.
- Saturation: only source 3 requests for 20 cycles with MAX_HOLD = 4 → grant stays 8'h08 throughout. When req[5] rises, source 5 is granted on the next edge.
- Simultaneous release and hold limit: at hold_cnt = MAX_HOLD-1, req changes from 8'h05 to 8'h04 → grant = 8'h04 next cycle and ptr = 3, advanced once.
- Reset mid-grant: reset asserted while source 2 is mid-hold → the next edge shows all outputs 0 and ptr = 0. With req = 8'hFF, source 0 is granted first after reset deasserts.

Source files
------------

// File: rtl/mux_rr_scheduler_pkg.sv
// rtl/mux_rr_scheduler_pkg.sv - shared widths and state encoding for the round-robin mux scheduler
package mux_rr_scheduler_pkg;

    localparam int N_SRC = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_scheduler_pick.sv
// rtl/mux_rr_scheduler_pick.sv - combinational rotating-priority picker
module rr_pick
    import mux_rr_scheduler_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [SEL_W-1:0] excl_idx,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the candidate nearest ptr is kept last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand] && !(excl_en && (cand == excl_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin owner of a shared 8-to-1 bit mux with bounded hold
module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] in,
    output logic [N_SRC-1:0] grant,
    output logic [SEL_W-1:0] select,
    output logic             active,
    output logic             out,
    output logic             out_valid
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             take;

    // One picker serves both the idle pick and the handover pick; the owner is masked while granted.
    rr_pick u_pick (
        .req      (req),
        .ptr      (ptr),
        .excl_en  (state == ST_GRANT),
        .excl_idx (sel_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            sel_q     <= sel_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            out       <= active ? in[sel_q] : 1'b0;
            out_valid <= active;
        end
    end

    // A release at the hold limit takes the release branch, so ptr advances only once.
    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        take    = 1'b0;
        case (state)
            ST_IDLE: take = pick_found;
            ST_GRANT: begin
                if (!req[sel_q]) begin
                    take = pick_found;
                    if (!pick_found) begin
                        state_n = ST_IDLE;
                        hold_n  = '0;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    take = pick_found;
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (take) begin
            state_n = ST_GRANT;
            sel_n   = pick_idx;
            ptr_n   = pick_idx + SEL_W'(1);
            hold_n  = '0;
        end
    end

    always_comb begin
        active = (state == ST_GRANT);
        select = sel_q;
        grant  = active ? (N_SRC'(1) << sel_q) : '0;
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb/tb_mux_rr_scheduler.sv - self-checking bench for mux_rr_scheduler against a behavioural model
module tb_mux_rr_scheduler;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] in = '0;
    logic [7:0] grant;
    logic [2:0] select;
    logic       active;
    logic       out;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    int m_owner = -1;
    int m_ptr = 0;
    int m_held = 0;
    bit m_out = 0;
    bit m_outv = 0;

    mux_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in        (in),
        .grant     (grant),
        .select    (select),
        .active    (active),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p, input int excl);
        for (int i = 0; i < 8; i++) begin
            int c;
            c = (p + i) % 8;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [7:0] r, input logic [7:0] d, input logic rs);
        int c;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_out = 0; m_outv = 0;
            return;
        end
        m_out  = (m_owner >= 0) ? d[m_owner] : 1'b0;
        m_outv = (m_owner >= 0);
        c = -1;
        if (m_owner < 0) begin
            c = pick(r, m_ptr, -1);
        end else if (!r[m_owner]) begin
            c = pick(r, m_ptr, m_owner);
            if (c < 0) m_owner = -1;
        end else if (m_held == MAX_HOLD - 1) begin
            c = pick(r, m_ptr, m_owner);
        end else begin
            m_held++;
        end
        if (c >= 0) begin
            m_owner = c;
            m_ptr   = (c + 1) % 8;
            m_held  = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        chk("grant", grant, eg);
        chk("active", {7'b0, active}, {7'b0, m_owner >= 0});
        chk("out", {7'b0, out}, {7'b0, m_out});
        chk("out_valid", {7'b0, out_valid}, {7'b0, m_outv});
        chk("ptr", {5'b0, dut.ptr}, 8'(m_ptr));
        if (m_owner >= 0) chk("select", {5'b0, select}, 8'(m_owner));
    endtask

    task automatic step(input logic [7:0] r, input logic rs);
        logic [7:0] d;
        d = 8'($urandom);
        req = r; in = d; reset = rs;
        @(posedge clk);
        model_edge(r, d, rs);
        #1;
        check_all();
    endtask

    initial begin
        // reset state
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        chk("reset_grant", grant, 8'h00);

        // single request
        step(8'h10, 1'b0);
        chk("single_grant", grant, 8'h10);
        chk("single_ptr", {5'b0, dut.ptr}, 8'h05);
        step(8'h10, 1'b0);
        step(8'h10, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // wrap: get ptr to 6, then sources 0 and 6
        step(8'h20, 1'b0);
        step(8'h00, 1'b0);
        step(8'h41, 1'b0);
        chk("wrap_first", grant, 8'h40);
        step(8'h01, 1'b0);
        chk("wrap_second", grant, 8'h01);
        chk("wrap_active", {7'b0, active}, 8'h01);
        step(8'h00, 1'b0);

        // hold limit alternation
        step(8'h00, 1'b1);
        for (int i = 0; i < 20; i++) step(8'h03, 1'b0);
        step(8'h00, 1'b0);

        // saturation then preemption
        step(8'h00, 1'b1);
        for (int i = 0; i < 20; i++) step(8'h08, 1'b0);
        chk("sat_grant", grant, 8'h08);
        step(8'h28, 1'b0);
        chk("sat_preempt", grant, 8'h20);
        step(8'h00, 1'b0);

        // release coincident with hold limit
        step(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) step(8'h05, 1'b0);
        step(8'h04, 1'b0);
        chk("simul_grant", grant, 8'h04);
        chk("simul_ptr", {5'b0, dut.ptr}, 8'h03);

        // reset mid-grant
        step(8'h00, 1'b1);
        step(8'h04, 1'b0);
        step(8'h04, 1'b0);
        step(8'hFF, 1'b1);
        chk("midrst_grant", grant, 8'h00);
        step(8'hFF, 1'b0);
        chk("midrst_first", grant, 8'h01);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            step(r, ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
